// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit that sits between the PC register, a
// variable-latency instruction memory and the decode stage. It issues one
// word-aligned request per PC value and holds the returned word until decode
// takes it. It also tells the next-PC logic when the PC may move to PC+4.
//
// Parameters
//   RESET_PC    PC value while in reset. The boot cycle steps past it without
//               fetching.
//   MAX_WAIT    number of unanswered request cycles before a fault is raised.
//               0 disables the timeout.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   instrAddr    current PC value
//   pcAdvance    combinational; 1 = next-PC logic selects PC+4 this edge
//   flush        redirect; next-PC logic loads the target this edge
//   memReq       instruction memory request
//   memAddr      request address (mirrors instrAddr)
//   memAck       one-cycle response strobe from memory
//   memRdata     instruction word, valid with memAck
//   instrValid   instr/instrPC hold a fetched word for decode
//   instr        fetched instruction word
//   instrPC      address the held word was fetched from
//   decodeReady  decode consumes the word when instrValid & decodeReady
//   fetchFault   sticky: misaligned PC or memory timeout
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'hFFFF_FFFC,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrAddr,
    output logic        pcAdvance,
    input  logic        flush,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic        instrValid,
    output logic [31:0] instr,
    output logic [31:0] instrPC,
    input  logic        decodeReady,
    output logic        fetchFault
);

    // The boot cycle advances by one word. This only lands on a word-aligned
    // PC if the reset PC itself is aligned.
    if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
        $error("instr_fetch: RESET_PC must be word aligned");
    end

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_REQ,
        ST_HOLD,
        ST_DRAIN,
        ST_FAULT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_next;
    logic          aligned;
    logic          wait_expired;
    logic          load_word;
    logic          clear_valid;
    logic          set_fault;

    // The memory has no abort, so the address is simply the live PC.
    // memReq decides whether that address is meaningful.
    assign memAddr = instrAddr;
    assign aligned = (instrAddr[1:0] == 2'b00);

    // wait_cnt holds the unanswered cycles already seen. The current cycle is
    // the last one allowed when one more would reach the limit.
    assign wait_expired = (MAX_WAIT != 0) &&
                          ((32'(wait_cnt) + 32'd1) == 32'(MAX_WAIT));

    // Next-state and output decode. The wait counter only keeps counting while
    // the FSM stays in REQ with no response. Every other path clears it, so
    // each entry into REQ starts a fresh timeout window. A flush that
    // coincides with memAck closes the current episode. That path also goes
    // back to REQ with a cleared count, ready for the redirected address.
    always_comb begin
        state_next    = state;
        wait_cnt_next = '0;
        memReq        = 1'b0;
        pcAdvance     = 1'b0;
        load_word     = 1'b0;
        clear_valid   = 1'b0;
        set_fault     = 1'b0;
        case (state)
            ST_BOOT: begin
                pcAdvance  = 1'b1;
                state_next = ST_REQ;
            end
            ST_REQ: begin
                if (!aligned) begin
                    set_fault  = 1'b1;
                    state_next = ST_FAULT;
                end else begin
                    memReq = 1'b1;
                    if (memAck && !flush) begin
                        load_word  = 1'b1;
                        pcAdvance  = 1'b1;
                        state_next = ST_HOLD;
                    end else if (memAck && flush) begin
                        state_next = ST_REQ;
                    end else if (flush) begin
                        state_next = ST_DRAIN;
                    end else if (wait_expired) begin
                        set_fault  = 1'b1;
                        state_next = ST_FAULT;
                    end else begin
                        wait_cnt_next = wait_cnt + CW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (flush || decodeReady) begin
                    clear_valid = 1'b1;
                    state_next  = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // The outstanding answer belongs to the abandoned address.
                // Swallow it, whatever flushes arrive meanwhile.
                if (memAck) begin
                    state_next = ST_REQ;
                end
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_BOOT;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Holding register for decode. instr/instrPC change only on an accepted
    // response, so they stay stable for as long as instrValid is high. The
    // fault flag is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrValid <= 1'b0;
            instr      <= '0;
            instrPC    <= '0;
            fetchFault <= 1'b0;
        end else begin
            if (load_word) begin
                instr      <= memRdata;
                instrPC    <= instrAddr;
                instrValid <= 1'b1;
            end else if (clear_valid) begin
                instrValid <= 1'b0;
            end
            if (set_fault) begin
                fetchFault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. The bench acts as the PC register and
// as a randomized variable-latency memory. A flag-based model of the fetch
// protocol predicts every output in every cycle: whether a word is held,
// whether an answer is still owed to a flushed request, and whether the unit
// has faulted.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;
    localparam int          MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instrAddr = RESET_PC;
    logic        pcAdvance;
    logic        flush = 1'b0;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck = 1'b0;
    logic [31:0] memRdata = '0;
    logic        instrValid;
    logic [31:0] instr;
    logic [31:0] instrPC;
    logic        decodeReady = 1'b0;
    logic        fetchFault;

    instr_fetch #(
        .RESET_PC (RESET_PC),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instrAddr   (instrAddr),
        .pcAdvance   (pcAdvance),
        .flush       (flush),
        .memReq      (memReq),
        .memAddr     (memAddr),
        .memAck      (memAck),
        .memRdata    (memRdata),
        .instrValid  (instrValid),
        .instr       (instr),
        .instrPC     (instrPC),
        .decodeReady (decodeReady),
        .fetchFault  (fetchFault)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: PC register, memory episode and fetch bookkeeping.
    logic [31:0] pc;
    bit          booting;
    bit          faulted;
    bit          holding;
    bit          draining;
    logic [31:0] held_word;
    logic [31:0] held_pc;
    int          waited;
    int          mem_left;
    bit          exp_req;
    bit          exp_adv;
    bit          fetching;
    logic [31:0] flush_target = '0;

    // Stimulus knobs.
    int lat_min   = 1;
    int lat_max   = 1;
    int flush_pct = 0;
    int ready_pct = 100;
    bit never_ack = 1'b0;
    bit force_flush = 1'b0;
    logic [31:0] forced_target = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        pc        = RESET_PC;
        booting   = 1'b1;
        faulted   = 1'b0;
        holding   = 1'b0;
        draining  = 1'b0;
        held_word = '0;
        held_pc   = '0;
        waited    = 0;
        mem_left  = 0;
    endtask

    task automatic setKnobs(input int lmin, input int lmax, input int fpct,
                            input int rpct, input bit never);
        lat_min   = lmin;
        lat_max   = lmax;
        flush_pct = fpct;
        ready_pct = rpct;
        never_ack = never;
    endtask

    // Choose this cycle's inputs from the model's view of the unit.
    task automatic applyStimulus();
        fetching = !booting && !faulted && !holding && !draining;
        exp_req  = fetching && (pc[1:0] == 2'b00);
        if (exp_req && mem_left == 0) begin
            mem_left = never_ack ? 1000000 : int'($urandom_range(lat_max, lat_min));
        end
        memAck   = (mem_left == 1);
        // A stray strobe during the boot cycle must be ignored.
        if (booting) memAck = 1'($urandom_range(1, 0));
        memRdata    = $urandom();
        decodeReady = ($urandom_range(99, 0) < ready_pct);
        flush       = 1'b0;
        if ((fetching || holding || draining) && !(draining && memAck)) begin
            flush = ($urandom_range(99, 0) < flush_pct);
        end
        flush_target = 32'($urandom_range(255, 0)) << 2;
        if (force_flush && fetching) begin
            flush        = 1'b1;
            flush_target = forced_target;
            force_flush  = 1'b0;
        end
        exp_adv   = booting || (exp_req && memAck && !flush);
        instrAddr = pc;
    endtask

    task automatic modelStep();
        logic [31:0] next_pc;
        next_pc = flush ? flush_target : (exp_adv ? pc + 32'd4 : pc);
        if (booting) begin
            booting = 1'b0;
            waited  = 0;
        end else if (faulted) begin
            waited = 0;
        end else if (holding) begin
            if (flush || decodeReady) holding = 1'b0;
            waited = 0;
        end else if (draining) begin
            if (memAck) draining = 1'b0;
            waited = 0;
        end else if (pc[1:0] != 2'b00) begin
            faulted = 1'b1;
            waited  = 0;
        end else if (memAck && !flush) begin
            holding   = 1'b1;
            held_word = memRdata;
            held_pc   = pc;
            waited    = 0;
        end else if (memAck) begin
            waited = 0;
        end else if (flush) begin
            draining = 1'b1;
            waited   = 0;
        end else begin
            waited++;
            if (MAX_WAIT != 0 && waited == MAX_WAIT) faulted = 1'b1;
        end
        if (mem_left > 0) mem_left--;
        pc = next_pc;
    endtask

    task automatic runCycle();
        @(negedge clk);
        applyStimulus();
        #1;
        checkOutput("memReq",     32'(memReq),     32'(exp_req));
        checkOutput("memAddr",    memAddr,         pc);
        checkOutput("pcAdvance",  32'(pcAdvance),  32'(exp_adv));
        checkOutput("instrValid", 32'(instrValid), 32'(holding));
        checkOutput("instr",      instr,           held_word);
        checkOutput("instrPC",    instrPC,         held_pc);
        checkOutput("fetchFault", 32'(fetchFault), 32'(faulted));
        modelStep();
    endtask

    task automatic checkZeroOutputs(input string pfx);
        checkOutput({pfx, "_memReq"},     32'(memReq),     32'd0);
        checkOutput({pfx, "_instrValid"}, 32'(instrValid), 32'd0);
        checkOutput({pfx, "_instr"},      instr,           32'd0);
        checkOutput({pfx, "_instrPC"},    instrPC,         32'd0);
        checkOutput({pfx, "_fetchFault"}, 32'(fetchFault), 32'd0);
    endtask

    // Assert reset, check the reset values, release just after a rising edge
    // so that the next cycle is the boot cycle.
    task automatic doReset();
        rst         = 1'b1;
        flush       = 1'b0;
        memAck      = 1'b0;
        decodeReady = 1'b0;
        memRdata    = '0;
        modelReset();
        instrAddr = pc;
        @(negedge clk);
        #1;
        checkZeroOutputs("rst");
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Reset in the middle of a cycle, well away from any clock edge.
    task automatic asyncResetCheck();
        @(negedge clk);
        applyStimulus();
        #1;
        checkOutput("pre_rst_memReq", 32'(memReq), 32'(exp_req));
        #1;
        rst = 1'b1;
        #1;
        checkZeroOutputs("async_rst");
        flush  = 1'b0;
        memAck = 1'b0;
        modelReset();
        instrAddr = pc;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        doReset();

        // Zero-wait memory, decode always ready.
        setKnobs(1, 1, 0, 100, 1'b0);
        repeat (12) runCycle();

        // Variable latency with back-pressure from decode.
        setKnobs(1, 4, 0, 40, 1'b0);
        repeat (60) runCycle();

        // Random redirects in every state that accepts them.
        setKnobs(1, 4, 15, 50, 1'b0);
        repeat (300) runCycle();

        // Redirect to a misaligned target; the fault must stick.
        setKnobs(1, 3, 0, 100, 1'b0);
        forced_target = 32'h0000_0002;
        force_flush   = 1'b1;
        repeat (20) runCycle();

        // A word is held, then memory stops answering and reset hits mid-wait.
        doReset();
        setKnobs(1, 2, 0, 0, 1'b0);
        repeat (20) runCycle();
        setKnobs(1, 1, 0, 100, 1'b1);
        repeat (5) runCycle();
        asyncResetCheck();
        setKnobs(1, 3, 0, 100, 1'b0);
        repeat (10) runCycle();

        // Memory never answers: timeout fault.
        doReset();
        setKnobs(1, 1, 0, 100, 1'b1);
        repeat (25) runCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
